// File: rtl/mux2x1_rr_arb.sv
// Round-robin select generator for a 2:1 mux: arbitrates two valid/ready sources
// and holds the granted word and its select in a 1-entry output register.
module mux2x1_rr_arb #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a0_valid,
    input  logic [WIDTH-1:0] a0,
    output logic             a0_ready,
    input  logic             a1_valid,
    input  logic [WIDTH-1:0] a1,
    output logic             a1_ready,
    output logic             s,
    output logic             y_valid,
    output logic [WIDTH-1:0] y,
    input  logic             y_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   prio;
    logic   can_load;
    logic   grant0;
    logic   grant1;

    assign y_valid  = (state == FULL);
    assign a0_ready = grant0;
    assign a1_ready = grant1;

    // Grant and next-state; prio breaks ties only when both sources are valid.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        can_load   = (state == EMPTY) | y_ready;
        if (!rst && can_load) begin
            if (a0_valid && (!a1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (a1_valid) begin
                grant1 = 1'b1;
            end
        end
        if (grant0 || grant1) begin
            state_next = FULL;
        end else if (state == FULL && y_ready) begin
            state_next = EMPTY;
        end
    end

    // State, output word/select and priority pointer; y and s hold on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            y     <= '0;
            s     <= 1'b0;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant0 || grant1) begin
                y    <= grant1 ? a1 : a0;
                s    <= grant1;
                prio <= grant0;
            end
        end
    end

endmodule
